// File: rtl/out_channel_drain_pkg.sv
// out_channel_pkg: shared types for the output-channel drain.
// Holds the FSM encoding, default widths and the count clamp.
package out_channel_pkg;

  localparam int DefMemoryElementWidth = 12;
  localparam int DefAddressWidth = 12;
  localparam int DefNOut = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  function automatic int unsigned clamp_count(
    input int unsigned count,
    input int unsigned lim
  );
    return (count < lim) ? count : lim;
  endfunction

endpackage

// File: rtl/out_channel_drain_if.sv
// out_channel_if: valid/ready word stream from the drain to the host.
// master drives the word, slave returns ready.
interface out_channel_if
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = DefMemoryElementWidth
) ();

  logic                          outValid;
  logic                          outReady;
  logic [MemoryElementWidth-1:0] outData;
  logic                          outLast;

  modport master (
    output outValid,
    output outData,
    output outLast,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outData,
    input  outLast,
    output outReady
  );

endinterface

// File: rtl/out_channel_drain_fifo.sv
// out_channel_fifo: 2-deep skid buffer between the read port and the stream.
// Push while full is accepted only when the head leaves on the same edge.
module out_channel_fifo
  import out_channel_pkg::*;
#(
  parameter int Width = DefMemoryElementWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       occupancy
);

  logic [Width-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against current fill level
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign full  = (occupancy == 2'd2);
  assign empty = (occupancy == 2'd0);
  assign dout  = mem[rd_ptr];

  // Storage, pointers and fill count
  always_ff @(posedge clock) begin
    if (reset) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      occupancy <= occupancy
                 + {1'b0, do_push}
                 - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/out_channel_drain.sv
// out_channel_drain: reads outMem[0..n-1] after the program finishes
// and streams the words to the host, flagging the last and raising done.
module out_channel_drain
  import out_channel_pkg::*;
#(
  parameter int          MemoryElementWidth = DefMemoryElementWidth,
  parameter int          AddressWidth       = DefAddressWidth,
  parameter int unsigned NOut               = DefNOut
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          finished,
  input  logic [AddressWidth:0]         count,
  output logic                          rdEnable,
  output logic [AddressWidth-1:0]       rdAddress,
  input  logic [MemoryElementWidth-1:0] rdData,
  out_channel_if.master                 stream,
  output logic                          done
);

  state_t state;
  state_t state_nxt;

  logic [AddressWidth:0]         n;
  logic [AddressWidth:0]         clamped;
  logic [AddressWidth:0]         issued;
  logic [AddressWidth:0]         sent;
  logic                          inflight;
  logic [1:0]                    occ;
  logic                          full;
  logic                          empty;
  logic [MemoryElementWidth-1:0] head;
  logic                          pop;
  logic                          issue;
  logic                          start;
  logic                          last;

  // Credit check, handshake and next-state decode
  always_comb begin
    clamped = (AddressWidth+1)'(
      clamp_count(32'(count), NOut));
    pop   = !empty && stream.outReady;
    last  = !empty && (sent == n - 1'b1);
    start = (state == IDLE) && finished;
    issue = (state == READ)
         && (({1'b0, occ} + {2'b00, inflight})
             < (3'd2 + {2'b00, pop}));
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (finished) begin
          state_nxt = (clamped == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue && (issued + 1'b1 == n)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!finished) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Length latch, read address and word counters
  always_ff @(posedge clock) begin
    if (reset) begin
      n         <= '0;
      issued    <= '0;
      sent      <= '0;
      rdAddress <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (start) begin
        n         <= clamped;
        issued    <= '0;
        sent      <= '0;
        rdAddress <= '0;
      end else begin
        if (issue) begin
          issued <= issued + 1'b1;
          if (issued + 1'b1 != n) begin
            rdAddress <= rdAddress + 1'b1;
          end
        end
        if (pop) begin
          sent <= sent + 1'b1;
        end
      end
    end
  end

  out_channel_fifo #(
    .Width(MemoryElementWidth)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (inflight),
    .pop      (pop),
    .din      (rdData),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .occupancy(occ)
  );

  assign rdEnable        = issue;
  assign stream.outValid = !empty;
  assign stream.outData  = head;
  assign stream.outLast  = last;
  assign done            = (state == DONE);

endmodule

// File: tb/tb_out_channel_drain.sv
// tb_out_channel_drain: directed and randomized drains against a
// queue-based model of the expected word stream.
module tb_out_channel_drain;

  localparam int MW = 12;
  localparam int AW = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic sel;

  logic          fin_a, fin_b;
  logic [AW:0]   cnt_a, cnt_b;
  logic          rdy_a, rdy_b;
  logic          rde_a, rde_b;
  logic [AW-1:0] rda_a, rda_b;
  logic [MW-1:0] rdq_a, rdq_b;
  logic          dn_a, dn_b;

  logic [MW-1:0] mem [16];
  logic [0:7]    pat;

  int checks = 0;
  int errors = 0;

  out_channel_if #(.MemoryElementWidth(MW)) ifa ();
  out_channel_if #(.MemoryElementWidth(MW)) ifb ();

  assign ifa.outReady = rdy_a;
  assign ifb.outReady = rdy_b;

  out_channel_drain #(
    .MemoryElementWidth(MW),
    .AddressWidth(AW),
    .NOut(6)
  ) dut_a (
    .clock    (clock),
    .reset    (reset),
    .finished (fin_a),
    .count    (cnt_a),
    .rdEnable (rde_a),
    .rdAddress(rda_a),
    .rdData   (rdq_a),
    .stream   (ifa),
    .done     (dn_a)
  );

  out_channel_drain #(
    .MemoryElementWidth(MW),
    .AddressWidth(AW),
    .NOut(2)
  ) dut_b (
    .clock    (clock),
    .reset    (reset),
    .finished (fin_b),
    .count    (cnt_b),
    .rdEnable (rde_b),
    .rdAddress(rda_b),
    .rdData   (rdq_b),
    .stream   (ifb),
    .done     (dn_b)
  );

  // Synchronous memory: garbage on cycles with no read
  always @(posedge clock) begin
    rdq_a <= rde_a ? mem[rda_a] : MW'($urandom);
    rdq_b <= rde_b ? mem[rda_b] : MW'($urandom);
  end

  logic          v_val, v_last, v_done, v_rde;
  logic [MW-1:0] v_data;
  logic [AW-1:0] v_addr;

  always_comb begin
    v_val  = sel ? ifb.outValid : ifa.outValid;
    v_last = sel ? ifb.outLast  : ifa.outLast;
    v_data = sel ? ifb.outData  : ifa.outData;
    v_done = sel ? dn_b  : dn_a;
    v_rde  = sel ? rde_b : rde_a;
    v_addr = sel ? rda_b : rda_a;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_fin(input logic x);
    if (sel) fin_b = x;
    else fin_a = x;
  endtask

  task automatic set_rdy(input logic x);
    if (sel) rdy_b = x;
    else rdy_a = x;
  endtask

  task automatic set_cnt(input int c);
    if (sel) cnt_b = (AW+1)'(c);
    else cnt_a = (AW+1)'(c);
  endtask

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) mem[i] = MW'($urandom);
  endtask

  // mode 0: ready held, 1: fixed pattern, 2: random
  task automatic run_drain(input int c, input int lim,
                           input int mode, input bit drop);
    int nexp, got, iss, k, kfirst, klast;
    logic [MW-1:0] q[$];
    logic stalled, slast, r, fin_seen;
    logic [MW-1:0] sdata;
    nexp = (c < lim) ? c : lim;
    for (int i = 0; i < nexp; i++) q.push_back(mem[i]);
    got = 0; iss = 0; k = 0; kfirst = -1; klast = 0;
    stalled = 1'b0; slast = 1'b0; sdata = '0;
    fin_seen = 1'b0;
    set_cnt(c);
    set_fin(1'b1);
    set_rdy(1'b0);
    while (!fin_seen && k < 200) begin
      @(negedge clock);
      k++;
      if (drop && k == 2) set_fin(1'b0);
      if (v_done) begin
        check("done_edge", k, klast + 1);
        check("done_words", got, nexp);
        check("done_rde", v_rde, 0);
        check("done_valid", v_val, 0);
        fin_seen = 1'b1;
      end else begin
        if (stalled) begin
          check("stall_valid", v_val, 1);
          check("stall_data", v_data, sdata);
          check("stall_last", v_last, slast);
        end
        if (v_val) begin
          if (kfirst < 0) begin
            kfirst = k;
            check("first_valid", k, 3);
          end
          if (got < nexp) begin
            check("data", v_data, q[got]);
            check("last", v_last, got == nexp - 1);
          end else begin
            check("extra_word", v_val, 0);
          end
        end
        case (mode)
          0: r = 1'b1;
          1: r = pat[(k - 1) % 8];
          default: r = 1'($urandom_range(0, 1));
        endcase
        set_rdy(r);
        #1;
        if (v_rde) begin
          check("rd_addr", v_addr, iss);
          iss++;
        end
        if (v_val && r) begin
          got++;
          klast = k;
        end
        check("outstanding", (iss - got) <= 2, 1);
        check("reads_max", iss <= nexp, 1);
        stalled = v_val && !r;
        sdata = v_data;
        slast = v_last;
      end
    end
    if (!fin_seen) check("timeout", 0, 1);
    if (mode == 0 && nexp > 0) begin
      check("consecutive", klast - kfirst, nexp - 1);
    end
    set_rdy(1'b0);
  endtask

  task automatic finish_run();
    set_fin(1'b0);
    @(negedge clock);
    check("done_clear", v_done, 0);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rde"}, v_rde, 0);
    check({tag, "_addr"}, v_addr, 0);
    check({tag, "_valid"}, v_val, 0);
    check({tag, "_data"}, v_data, 0);
    check({tag, "_last"}, v_last, 0);
    check({tag, "_done"}, v_done, 0);
  endtask

  initial begin
    pat = 8'b0100_1101;
    sel = 1'b0;
    reset = 1'b1;
    fin_a = 1'b0; fin_b = 1'b0;
    cnt_a = '0; cnt_b = '0;
    rdy_a = 1'b0; rdy_b = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset_a");
    sel = 1'b1;
    check_reset_outputs("reset_b");
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // Basic drain
    mem[0] = 12'd2; mem[1] = 12'd5; mem[2] = 12'd7;
    run_drain(3, 6, 0, 1'b0);
    finish_run();

    // Empty channel
    run_drain(0, 6, 0, 1'b0);
    finish_run();

    // Backpressure
    mem[0] = 12'd1; mem[1] = 12'd2;
    mem[2] = 12'd3; mem[3] = 12'd4;
    run_drain(4, 6, 1, 1'b0);
    finish_run();

    // Clamp on the NOut=2 instance
    sel = 1'b1;
    fill(5);
    run_drain(5, 2, 2, 1'b0);
    finish_run();
    sel = 1'b0;

    // Reset after the first word
    fill(3);
    set_cnt(3);
    set_fin(1'b1);
    set_rdy(1'b1);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_valid", v_val, 1);
    check("pre_rst_data", v_data, mem[0]);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    set_rdy(1'b0);
    run_drain(3, 6, 2, 1'b0);

    // Re-arm: no second drain while finished stays high
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_done", v_done, 1);
      check("hold_rde", v_rde, 0);
      check("hold_valid", v_val, 0);
    end
    set_fin(1'b0);
    @(negedge clock);
    check("idle_done", v_done, 0);
    @(negedge clock);
    check("idle_done2", v_done, 0);
    fill(1);
    run_drain(1, 6, 2, 1'b0);
    finish_run();

    // Randomized drains, some dropping finished mid-drain
    for (int t = 0; t < 8; t++) begin
      fill(8);
      run_drain($urandom_range(0, 8), 6,
                $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
      finish_run();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_channel_drain.md
# out_channel_drain

Host-side reader for the program output channel. Once the test program raises `finished`, this block reads the output memory words `0 .. count-1` through a synchronous read port with one-cycle latency, the same timing as `heapMemory`. It presents each word on a valid/ready stream to the host or test harness, marks the final word, and raises `done`. It is the consuming end of the channel that the program writes with `outMem[outMemPos]`.

## Interface
- `MemoryElementWidth`, 12, width of one channel word
- `AddressWidth`, 12, read-address width; the channel holds at most 2**AddressWidth words
- `NOut`, 1, configured channel size; `count` is clamped to this value
- `clock`  in  1  driving clock; one clock domain, all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `finished`  in  1  program-finished level from the program core
- `count`  in  AddressWidth+1  number of words written (`outMemPos`); sampled once, at start
- `rdEnable`  out  1  read strobe to the output memory
- `rdAddress`  out  AddressWidth  read address
- `rdData`  in  MemoryElementWidth  read data, valid on the cycle after `rdEnable`
- `outValid`  out  1  stream word available
- `outReady`  in  1  host accepts the word
- `outData`  out  MemoryElementWidth  stream word
- `outLast`  out  1  current word is the final one
- `done`  out  1  drain complete; held until re-armed

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - `finished`=1 latches `n = min(count, NOut)` and clears the address and sent counters.
  - If n=0, go to DONE; otherwise go to READ.
- READ:
  - Assert `rdEnable` with `rdAddress` = next address when `occupancy + inflight - pop < 2`, where pop = `outValid && outReady` this cycle.
  - Increment the address on each issued read.
  - Once n reads have been issued, go to DRAIN.
- DRAIN: no reads. When the word with `outLast` set is accepted, go to DONE.
- DONE:
  - `done`=1. Return to IDLE only once `finished`=0, so each program run is drained exactly once.
- Buffer: a 2-entry FIFO captures `rdData` on the cycle after each issued read.
  - `outValid` = FIFO not empty; `outData` = FIFO head.
  - `outLast` = head is word n-1, tracked by a sent counter, AddressWidth+1 bits wide.
- Stream rules:
  - `outData` and `outLast` stay stable while `outValid && !outReady`.
  - A transfer occurs only when `outValid && outReady`.
  - Words leave in ascending address order, with no duplicates and no drops.
- Simultaneous push and pop on the same cycle: occupancy is unchanged and order is preserved.
- `count` and `rdData` changes outside their sample points are ignored.
- `finished` falling mid-drain does not abort the drain. The block still completes, then passes through DONE to IDLE.

## Timing
- Reset:
  - State goes to IDLE and the FIFO empties.
  - `rdEnable`=0, `rdAddress`=0, `outValid`=0, `outData`=0, `outLast`=0, `done`=0.
  - Any in-flight read return is discarded.
- `reset` overrides everything on the same edge, including mid-drain.
- Latency: with `finished` sampled high on edge E0:
  - `rdEnable` is high in the cycle after E0.
  - `rdData` returns after E1 and is captured at E2.
  - `outValid` is first high after E2, i.e. 3 edges after E0 counting E0.
- Throughput: with `outReady` held at 1, one word per clock after the first. n words occupy n consecutive `outValid` cycles.
- n=0: DONE is reached on the edge after E0; `outValid` never rises.
- `done` rises on the edge after the last-word transfer.
- The `rdAddress` counter stops at n-1; it never wraps within a drain.

## Structure
- Package `out_channel_pkg`: state enum {IDLE, READ, DRAIN, DONE}, default width constants, and the clamp function `min(count, NOut)`.
- Sub-module `out_channel_fifo`: 2-deep synchronous FIFO with push, pop, full, empty and 2-bit occupancy.
- The FSM, credit check and counters live in the top module.
- Target size is 150–250 lines in total.

## Test plan
1. Basic drain, no backpressure:
   - Stimulus: memory = {2, 5, 7}, count=3, `outReady`=1, raise `finished`.
   - Required: `outData` 2, 5, 7 on 3 consecutive cycles, with `outLast` only with 7; first `outValid` 3 edges after E0; `done`=1 on the following edge.
2. Empty channel:
   - Stimulus: count=0, raise `finished`.
   - Required: `rdEnable` never high, `outValid` never high, `done`=1 one edge after E0.
3. Backpressure:
   - Stimulus: count=4, memory = {1, 2, 3, 4}, `outReady` pattern 0, 1, 0, 0, 1, 1, 0, 1, ...
   - Required: exactly 1, 2, 3, 4 delivered; data stable while stalled; outstanding reads (FIFO occupancy + in-flight) never exceed 2.
4. Clamp:
   - Stimulus: NOut=2, count=5.
   - Required: exactly 2 words delivered, `outLast` on the second.
5. Reset mid-drain:
   - Stimulus: assert `reset` after 1 of 3 words has been delivered.
   - Required: next cycle all outputs are at their reset values; with `finished` still high, a fresh drain delivers all 3 words from address 0.
6. Re-arm:
   - Stimulus: after DONE, hold `finished`=1 for 10 cycles, then drop it, then raise it again with count=1.
   - Required: no second drain while `finished` stays high; exactly one word after the re-raise; `done` low in IDLE, high again afterwards.
